// File: rtl/imem_loader.sv
// Boot loader: frames UART bytes into little-endian words, writes them into the
// instruction SRAM, verifies an XOR checksum and releases the core on success.
module imem_loader #(
  parameter int         ADDR_WIDTH     = 5,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] ACK_BYTE       = 8'h4B,
  parameter logic [7:0] NAK_BYTE       = 8'h45
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic [31:0] imem_din,
  output logic [31:0] imem_addr,
  output logic        imem_web,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err
);

  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0]      CAP32    = 32'd1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] len_q, len_d, idx_q, idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [23:0]      asm_q, asm_d;
  logic [7:0]       csum_q, csum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             web_q, web_d;
  logic [31:0]      addr_q, addr_d, din_q, din_d;
  logic             cpu_rst_q, cpu_rst_d, done_q, done_d, err_q, err_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic             go_done, go_err, tick, last_word, len_bad;
  logic [IDX_W-1:0] idx_inc;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    cnt_d      = cnt_q;
    web_d      = web_q;
    addr_d     = addr_q;
    din_d      = din_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    go_done    = 1'b0;
    go_err     = 1'b0;
    tick       = 1'b0;
    idx_inc    = idx_q + IDX_W'(1);
    last_word  = (idx_inc == len_q);
    len_bad    = (rx_data == 8'd0) || ({24'd0, rx_data} > CAP32);

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d   = S_LEN;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          csum_d    = 8'd0;
          idx_d     = '0;
          lane_d    = 2'd0;
          cnt_d     = '0;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (len_bad) begin
            go_err = 1'b1;
          end else begin
            len_d   = IDX_W'(rx_data);
            state_d = S_DATA;
          end
        end else begin
          tick = 1'b1;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          cnt_d  = '0;
          csum_d = csum_q ^ rx_data;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: asm_d[7:0]   = rx_data;
            2'd1: asm_d[15:8]  = rx_data;
            2'd2: asm_d[23:16] = rx_data;
            default: begin
              web_d   = 1'b0;
              addr_d  = 32'(idx_q) << 2;
              din_d   = {rx_data, asm_q};
              state_d = S_WRITE;
            end
          endcase
        end else begin
          tick = 1'b1;
        end
      end
      S_WRITE: begin
        web_d   = 1'b1;
        idx_d   = idx_inc;
        state_d = last_word ? S_CHECK : S_DATA;
        // A byte landing on the write cycle is either the next word's lane 0
        // or, after the final word, the checksum itself.
        if (rx_valid) begin
          cnt_d = '0;
          if (last_word) begin
            go_done = (rx_data == csum_q);
            go_err  = (rx_data != csum_q);
          end else begin
            asm_d[7:0] = rx_data;
            csum_d     = csum_q ^ rx_data;
            lane_d     = 2'd1;
          end
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          cnt_d   = '0;
          go_done = (rx_data == csum_q);
          go_err  = (rx_data != csum_q);
        end else begin
          tick = 1'b1;
        end
      end
      S_DONE, S_ERR: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tick) begin
      if (cnt_q == CNT_LAST) go_err = 1'b1;
      else                   cnt_d  = cnt_q + CNT_W'(1);
    end

    if (go_done) begin
      state_d    = S_DONE;
      done_d     = 1'b1;
      cpu_rst_d  = 1'b0;
      tx_valid_d = 1'b1;
      tx_data_d  = ACK_BYTE;
    end else if (go_err) begin
      state_d    = S_ERR;
      err_d      = 1'b1;
      cpu_rst_d  = 1'b1;
      tx_valid_d = 1'b1;
      tx_data_d  = NAK_BYTE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      lane_q     <= 2'd0;
      asm_q      <= 24'd0;
      csum_q     <= 8'd0;
      cnt_q      <= '0;
      web_q      <= 1'b1;
      addr_q     <= 32'd0;
      din_q      <= 32'd0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      cnt_q      <= cnt_d;
      web_q      <= web_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign imem_din  = din_q;
  assign imem_addr = addr_q;
  assign imem_web  = web_q;
  assign cpu_rst   = cpu_rst_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scenario bench for imem_loader: expected SRAM writes and status bytes are
// queued as stimulus is driven and popped when the loader produces them.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int         AW   = 5;
  localparam int         TO   = 50;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h4B;
  localparam logic [7:0] NAK  = 8'h45;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [31:0] imem_din, imem_addr;
  logic        imem_web, cpu_rst, load_done, load_err;

  imem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO),
                .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .imem_din(imem_din), .imem_addr(imem_addr), .imem_web(imem_web),
    .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err));

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] wq[$];
  logic [7:0]  tq[$];
  logic [31:0] fw[$];
  bit          web_prev_low = 1'b0;

  // SRAM write port scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!imem_web) begin
      n_cmp++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%h din=%h required=none", imem_addr, imem_din);
      end else begin
        logic [63:0] e;
        e = wq.pop_front();
        if ({imem_addr, imem_din} !== e) begin
          n_fail++;
          $display("FAIL write addr/din got=%h/%h required=%h/%h", imem_addr, imem_din, e[63:32], e[31:0]);
        end
      end
      if (web_prev_low) begin
        n_cmp++;
        n_fail++;
        $display("FAIL web_width got=low_two_cycles required=one_cycle addr=%h", imem_addr);
      end
    end
    web_prev_low = !imem_web;
  end

  // Status byte scoreboard on the handshake cycle.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      n_cmp++;
      if (tq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tx got=%h required=none", tx_data);
      end else begin
        logic [7:0] e;
        e = tq.pop_front();
        if (tx_data !== e) begin
          n_fail++;
          $display("FAIL tx_data got=%h required=%h", tx_data, e);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((tq.size() != 0 || wq.size() != 0 || tx_valid) && k < 300) begin
      @(posedge clk); #1; k++;
    end
    n_cmp++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL %s_drain got pending_tx=%0d pending_wr=%0d required=0", name, tq.size(), wq.size());
    end
  endtask

  // Sends fw[] as data bytes plus checksum; queues the expected writes and status.
  task automatic send_words(input int gap, input bit corrupt);
    logic [7:0] cs = 8'd0;
    for (int i = 0; i < fw.size(); i++) begin
      for (int b = 0; b < 4; b++) begin
        logic [7:0] v;
        v = fw[i][8*b +: 8];
        cs ^= v;
        if (b == 3) wq.push_back({32'(i * 4), fw[i]});
        send_byte(v);
        idle(gap);
      end
    end
    tq.push_back(corrupt ? NAK : ACK);
    send_byte(corrupt ? 8'h00 : cs);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #2;
    n_cmp += 8;
    if (imem_web !== 1'b1) begin n_fail++; $display("FAIL rst_web got=%b required=1", imem_web); end
    if (imem_din !== 32'd0) begin n_fail++; $display("FAIL rst_din got=%h required=0", imem_din); end
    if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_addr got=%h required=0", imem_addr); end
    if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_rst got=%b required=1", cpu_rst); end
    if (load_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b required=0", load_done); end
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b required=0", load_err); end
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got=%b required=0", tx_valid); end
    if (tx_data !== 8'd0) begin n_fail++; $display("FAIL rst_tx_data got=%h required=0", tx_data); end
    idle(3);
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    int k = 0;
    tx_ready = 1'b0;
    send_byte(8'h13);
    send_byte(SYNC);
    send_byte(8'h01);
    fw = '{32'h0000_0013};
    send_words(1, 1'b0);
    while (!tx_valid && k < 20) begin @(posedge clk); #1; k++; end
    n_cmp += 3;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_tx_valid got=%b required=1", tx_valid); end
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL single_done got=%b required=1", load_done); end
    if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL single_cpu_rst got=%b required=0", cpu_rst); end
    send_byte(SYNC);
    idle(3);
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== ACK) begin
      n_fail++;
      $display("FAIL single_hold got=%b/%h required=1/%h", tx_valid, tx_data, ACK);
    end
    tx_ready = 1'b1;
    wait_idle("single");
    n_cmp += 2;
    if (load_done !== 1'b1 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_levels got=%b/%b required=1/0", load_done, load_err);
    end
    if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL single_release got=%b required=0", cpu_rst); end
  endtask

  task automatic test_back_to_back();
    send_byte(SYNC);
    n_cmp++;
    if (cpu_rst !== 1'b1 || load_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_cpu_rst got=%b/%b required=1/0", cpu_rst, load_done);
    end
    send_byte(8'h02);
    fw = '{32'h0000_0093, 32'h0010_0113};
    send_words(0, 1'b0);
    wait_idle("b2b");
    n_cmp++;
    if (load_done !== 1'b1 || cpu_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done got=%b/%b required=1/0", load_done, cpu_rst);
    end
  endtask

  task automatic test_bad_csum();
    send_byte(SYNC);
    send_byte(8'h01);
    fw = '{32'h0000_0013};
    send_words(0, 1'b1);
    wait_idle("csum");
    n_cmp++;
    if (load_err !== 1'b1 || load_done !== 1'b0 || cpu_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL csum_err got=%b/%b/%b required=1/0/1", load_err, load_done, cpu_rst);
    end
  endtask

  task automatic test_bad_len(input logic [7:0] n);
    send_byte(SYNC);
    tq.push_back(NAK);
    send_byte(n);
    n_cmp++;
    if (tx_valid !== 1'b1 || load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL len_%h got=%b/%b required=1/1", n, tx_valid, load_err);
    end
    wait_idle("len");
  endtask

  task automatic test_full();
    fw = {};
    for (int i = 0; i < (1 << AW); i++) fw.push_back($urandom);
    fw[3] = 32'hA5A5_00A5;
    send_byte(SYNC);
    send_byte(8'h20);
    send_words(0, 1'b0);
    wait_idle("full");
    n_cmp++;
    if (load_done !== 1'b1 || cpu_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done got=%b/%b required=1/0", load_done, cpu_rst);
    end
  endtask

  task automatic test_timeout();
    int k = 0;
    send_byte(SYNC);
    send_byte(8'h01);
    tq.push_back(NAK);
    send_byte(8'h13);
    while (!tx_valid && k < 200) begin @(posedge clk); #1; k++; end
    n_cmp++;
    if (k != TO) begin n_fail++; $display("FAIL timeout_cycles got=%0d required=%0d", k, TO); end
    wait_idle("timeout");
    n_cmp++;
    if (load_err !== 1'b1 || cpu_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err got=%b/%b required=1/1", load_err, cpu_rst);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(SYNC);
    send_byte(8'h03);
    fw = '{32'h1122_3344, 32'hCAFE_F00D};
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 3) wq.push_back({32'(i * 4), fw[i]});
        send_byte(fw[i][8*b +: 8]);
      end
    end
    send_byte(8'h77);
    send_byte(8'h66);
    rst = 1'b0;
    #2;
    n_cmp += 3;
    if (imem_addr !== 32'd0 || imem_din !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_rst_sram got=%h/%h required=0/0", imem_addr, imem_din);
    end
    if (imem_web !== 1'b1 || cpu_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rst_ctrl got=%b/%b required=1/1", imem_web, cpu_rst);
    end
    if (load_done !== 1'b0 || load_err !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_status got=%b/%b/%b required=0/0/0", load_done, load_err, tx_valid);
    end
    idle(2);
    rst = 1'b1;
    idle(2);
    send_byte(SYNC);
    send_byte(8'h01);
    fw = '{32'hDEAD_BEEF};
    send_words(2, 1'b0);
    wait_idle("after_rst");
    n_cmp++;
    if (load_done !== 1'b1 || cpu_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL after_rst_done got=%b/%b required=1/0", load_done, cpu_rst);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_csum();
    test_bad_len(8'h00);
    test_bad_len(8'h21);
    test_full();
    test_timeout();
    test_reset_mid();
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
